// File: rtl/seg_s2p_rx.sv
`timescale 1ns/1ps
// seg_s2p_rx: serial-to-parallel receiver for the 7-segment serial link.
// Rebuilds the 64-bit segment word shifted out on seg_clk/seg_sout and commits
// it on the rising edge of SEG_PEN. Every link input is asynchronous to clk,
// so each one passes through a synchronizer chain before edge detection.
module seg_s2p_rx #(
  parameter int FRAME_BITS  = 64,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  seg_clk,
  input  logic                  seg_sout,
  input  logic                  SEG_PEN,
  input  logic                  seg_clrn,
  output logic [FRAME_BITS-1:0] P_Data,
  output logic                  frame_valid,
  output logic                  frame_err,
  output logic [7:0]            err_cnt,
  output logic                  busy
);

  // A chain shorter than two flops gives no metastability protection.
  localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  // The bit count has to hold FRAME_BITS+1, the overrun marker.
  localparam int CNT_W  = $clog2(FRAME_BITS + 2);
  localparam int TMO_W  = $clog2(TIMEOUT + 1);

  localparam logic [CNT_W-1:0] CNT_FULL    = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_OVERRUN = CNT_W'(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(FRAME_BITS - 1);
  localparam logic [TMO_W-1:0] TMO_LAST    = TMO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FULL  = 2'd2
  } state_t;

  // Synchronizer chains; bit 0 faces the pin.
  logic [STAGES-1:0] clk_sync_q,  clk_sync_d;
  logic [STAGES-1:0] sout_sync_q, sout_sync_d;
  logic [STAGES-1:0] pen_sync_q,  pen_sync_d;
  logic [STAGES-1:0] clrn_sync_q, clrn_sync_d;

  // Edge detection stage. Every conditioned signal gets exactly one extra
  // register here, so seg_clk, seg_sout, SEG_PEN and seg_clrn stay aligned.
  logic clk_prev_q, clk_prev_d;
  logic pen_prev_q, pen_prev_d;
  logic clk_rise_q, clk_rise_d;
  logic pen_rise_q, pen_rise_d;
  logic sout_q,     sout_d;
  logic clrn_q,     clrn_d;

  // Frame state.
  state_t                  state_q,   state_d;
  logic [CNT_W-1:0]        count_q,   count_d;
  logic [FRAME_BITS-1:0]   shreg_q,   shreg_d;
  logic [TMO_W-1:0]        tmo_q,     tmo_d;
  logic [FRAME_BITS-1:0]   p_data_q,  p_data_d;
  logic                    valid_q,   valid_d;
  logic                    err_q,     err_d;
  logic [7:0]              err_cnt_q, err_cnt_d;
  logic                    busy_q,    busy_d;

  logic                    count_is_full;
  logic                    tmo_expired;
  logic [7:0]              err_cnt_inc;

  // Next values of the synchronizer chains: shift each pin in one stage per clk.
  always_comb begin
    clk_sync_d  = {clk_sync_q[STAGES-2:0],  seg_clk};
    sout_sync_d = {sout_sync_q[STAGES-2:0], seg_sout};
    pen_sync_d  = {pen_sync_q[STAGES-2:0],  SEG_PEN};
    clrn_sync_d = {clrn_sync_q[STAGES-2:0], seg_clrn};
  end

  // Synchronizer flops; reset to the idle levels of the link.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync_q  <= '0;
      sout_sync_q <= '0;
      pen_sync_q  <= '0;
      clrn_sync_q <= '1;
    end else begin
      clk_sync_q  <= clk_sync_d;
      sout_sync_q <= sout_sync_d;
      pen_sync_q  <= pen_sync_d;
      clrn_sync_q <= clrn_sync_d;
    end
  end

  // Rising-edge detection on the synced shift clock and latch enable. Data is
  // taken from the same stage as seg_clk so the sampled bit matches its edge.
  always_comb begin
    clk_prev_d = clk_sync_q[STAGES-1];
    pen_prev_d = pen_sync_q[STAGES-1];
    clk_rise_d = clk_sync_q[STAGES-1] & ~clk_prev_q;
    pen_rise_d = pen_sync_q[STAGES-1] & ~pen_prev_q;
    sout_d     = sout_sync_q[STAGES-1];
    clrn_d     = clrn_sync_q[STAGES-1];
  end

  // Registered edge pulses and aligned data/clear levels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_prev_q <= 1'b0;
      pen_prev_q <= 1'b0;
      clk_rise_q <= 1'b0;
      pen_rise_q <= 1'b0;
      sout_q     <= 1'b0;
      clrn_q     <= 1'b1;
    end else begin
      clk_prev_q <= clk_prev_d;
      pen_prev_q <= pen_prev_d;
      clk_rise_q <= clk_rise_d;
      pen_rise_q <= pen_rise_d;
      sout_q     <= sout_d;
      clrn_q     <= clrn_d;
    end
  end

  assign count_is_full = (count_q == CNT_FULL);
  assign tmo_expired   = (tmo_q == TMO_LAST);
  assign err_cnt_inc   = (err_cnt_q == 8'hFF) ? err_cnt_q : (err_cnt_q + 8'd1);

  // Frame FSM next state. Events are resolved in priority order: clear, latch
  // enable, timeout, shift edge. A shift edge coinciding with the latch enable
  // is dropped so the committed frame is judged on the count it already had.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    shreg_d   = shreg_q;
    tmo_d     = tmo_q;
    p_data_d  = p_data_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    err_cnt_d = err_cnt_q;

    if (!clrn_q) begin
      state_d = IDLE;
      count_d = '0;
      shreg_d = '0;
      tmo_d   = '0;
    end else if (pen_rise_q && (state_q != IDLE)) begin
      if ((state_q == FULL) && count_is_full) begin
        p_data_d = shreg_q;
        valid_d  = 1'b1;
      end else begin
        err_d     = 1'b1;
        err_cnt_d = err_cnt_inc;
      end
      state_d = IDLE;
      count_d = '0;
      tmo_d   = '0;
    end else if ((state_q != IDLE) && !clk_rise_q && tmo_expired) begin
      err_d     = 1'b1;
      err_cnt_d = err_cnt_inc;
      state_d   = IDLE;
      count_d   = '0;
      tmo_d     = '0;
    end else if (clk_rise_q) begin
      shreg_d = {shreg_q[FRAME_BITS-2:0], sout_q};
      tmo_d   = '0;
      if (count_q != CNT_OVERRUN) begin
        count_d = count_q + 1'b1;
      end
      if (count_q >= CNT_LAST) begin
        state_d = FULL;
      end else begin
        state_d = SHIFT;
      end
    end else if (state_q != IDLE) begin
      tmo_d = tmo_q + 1'b1;
    end

    busy_d = (state_d != IDLE);
  end

  // Frame FSM and its registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      shreg_q   <= '0;
      tmo_q     <= '0;
      p_data_q  <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= 8'd0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      shreg_q   <= shreg_d;
      tmo_q     <= tmo_d;
      p_data_q  <= p_data_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
      busy_q    <= busy_d;
    end
  end

  assign P_Data      = p_data_q;
  assign frame_valid = valid_q;
  assign frame_err   = err_q;
  assign err_cnt     = err_cnt_q;
  assign busy        = busy_q;

endmodule

// File: doc/seg_s2p_rx.md
Name: seg_s2p_rx

Overview:
- Serial-to-parallel receiver for the 7-segment serial link. It recovers the 64-bit segment word that the display driver shifts out on seg_clk/seg_sout/SEG_PEN/seg_clrn.
- It is used for on-chip loopback checking of the display path, and as the receive end when a second board drives the segment chain.
- All link inputs are treated as asynchronous. They are synchronized and edge-detected in the clk domain, then a small FSM counts bits and latches complete frames.

Parameters:
- FRAME_BITS, 64, bits per frame; the latch is valid only at exactly this count.
- SYNC_STAGES, 2, synchronizer flops per link input (minimum 2).
- TIMEOUT, 1024, clk cycles without a seg_clk rising edge mid-frame before the frame is abandoned.

Ports:
- clk  in  1  system clock; must be at least 4x seg_clk frequency.
- rst  in  1  asynchronous active-high reset.
- seg_clk  in  1  link shift clock; data is sampled on its rising edge.
- seg_sout  in  1  link serial data, MSB (bit 63) first.
- SEG_PEN  in  1  link latch enable; its rising edge commits the frame.
- seg_clrn  in  1  link clear, active-low.
- P_Data  out  64  last committed frame.
- frame_valid  out  1  one-cycle pulse when P_Data updates.
- frame_err  out  1  one-cycle pulse on a rejected frame.
- err_cnt  out  8  saturating count of rejected frames.
- busy  out  1  high while the FSM is in SHIFT or FULL.

Behaviour:
- Reset (rst=1, asynchronous): P_Data=0, frame_valid=0, frame_err=0, err_cnt=0, busy=0, shift register=0, bit count=0, FSM=IDLE, synchronizer flops=reset-inactive levels (seg_clk 0, SEG_PEN 0, seg_clrn 1).
- Input conditioning: each input passes through SYNC_STAGES flops. clk_rise = synced seg_clk high AND its previous value low; pen_rise is detected the same way. seg_sout is sampled from the same synced stage as seg_clk so the two stay aligned.
- Shift: on clk_rise, shreg <= {shreg[62:0], sout_s} and count increments. Count saturates at FRAME_BITS+1, which marks overrun.
- FSM states:
  - IDLE: count=0. clk_rise -> SHIFT.
  - SHIFT: 1 <= count < FRAME_BITS. When count reaches FRAME_BITS -> FULL.
  - FULL: count >= FRAME_BITS. Further clk_rise edges keep shifting and set overrun.
- pen_rise in FULL with count == FRAME_BITS: P_Data <= shreg; frame_valid pulses; FSM -> IDLE; count <= 0.
- pen_rise in FULL with overrun, or in SHIFT: frame_err pulses, err_cnt increments (saturating at 255), P_Data is held, FSM -> IDLE, count <= 0.
- pen_rise in IDLE: ignored; no error.
- Latency: P_Data and frame_valid update SYNC_STAGES+2 clk cycles after the SEG_PEN rising edge on the pin.
- Clear: synced seg_clrn low forces IDLE, count=0, shreg=0. It has the highest priority after rst and takes effect while it is held low. P_Data and err_cnt are not affected. An abandoned partial frame is not counted as an error.
- Timeout: in SHIFT or FULL, a counter runs while no clk_rise occurs. When it reaches TIMEOUT: FSM -> IDLE, count=0, frame_err pulses, err_cnt increments. The counter reloads on every clk_rise.
- Simultaneous events within one cycle, highest priority first:
  1. clrn low
  2. pen_rise (evaluated against the count before this cycle; a coincident clk_rise is dropped)
  3. timeout
  4. clk_rise
- frame_valid and frame_err are never high in the same cycle.
- busy = (FSM != IDLE), registered.

Test Plan:
1. Nominal frame: clk=100 MHz, seg_clk=10 MHz. Shift 64'hDEADBEEF_01234567 MSB first, then pulse SEG_PEN. Required: frame_valid=1 for one cycle, P_Data=64'hDEADBEEF_01234567, err_cnt=0.
2. Short frame: shift 63 bits, then pulse SEG_PEN. Required: frame_err pulse, err_cnt=1, P_Data unchanged from the previous frame. Then send a full frame of 64'h0 -> P_Data=0 and frame_valid pulses.
3. Overrun: shift 65 bits, then pulse SEG_PEN. Required: frame_err pulse, err_cnt increments, busy=0 afterwards.
4. Clear mid-frame: after 30 bits, drive seg_clrn low for 3 seg_clk periods. Required: busy falls, err_cnt unchanged. A following full frame of 64'hFFFF_FFFF_FFFF_FFFF latches correctly.
5. Timeout and reset: stop seg_clk after 10 bits for TIMEOUT+5 cycles. Required: a single frame_err pulse and FSM back in IDLE. Separately, assert rst mid-frame: all outputs are 0 immediately, without waiting for a clk edge.
6. Saturation and coincidence: force 260 short frames -> err_cnt=255. Make seg_clk and SEG_PEN rise in the same synced cycle at count 64 -> frame accepted, and the coincident shift edge is discarded.
